cpu1_pc_sequencer: RTL and testbench
====================================

Name: cpu1_pc_sequencer

Overview:
Downstream of the branch-dispatch unit. Consumes its wake1, RegRuntime1, PC1 and PC1Load outputs and owns CPU1's program counter: holds CPU1 asleep, loads the dispatched start address, and steps or branches the PC while running. It also generates the CPU1Exit pulse that returns CPU1 to sleep. Feeds CPU1's instruction fetch and register-bank select.

Parameters:
PC_W, 32, program counter width
PC_STEP, 4, sequential increment in bytes
RESET_PC, 0, PC value on reset and while asleep
EXIT_TIMEOUT, 16, cycles allowed in EXIT for wake to drop before flagging an error
CNT_W, 16, width of the run-cycle counter

Ports:
sclk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
wake  in  1  from wake1; CPU1 permitted to run
runtime_sel  in  1  from RegRuntime1; register-bank instance to use
load_pc  in  1  from PC1Load; request to load pc_in
pc_in  in  PC_W  from PC1; start address
stall  in  1  CPU1 pipeline stall; freeze PC
branch_taken  in  1  CPU1 branch resolved taken this cycle
branch_target  in  PC_W  CPU1 branch destination
exit_req  in  1  CPU1 decoded its exit instruction
pc  out  PC_W  current CPU1 fetch address
fetch_en  out  1  CPU1 fetch/execute enable
runtime  out  1  latched bank select
cpu_exit  out  1  to CPU1Exit; single-cycle pulse
run_cycles  out  CNT_W  RUN cycles since last load, saturating
exit_err  out  1  sticky; wake was not dropped within EXIT_TIMEOUT
align_err  out  1  sticky misalignment flag (see Optional Feature)

Behaviour:
- Reset (reset=0, async): state=SLEEP, pc=RESET_PC, fetch_en=0, runtime=0, cpu_exit=0, run_cycles=0, exit_err=0, align_err=0, timeout counter=0.
- load_pc is edge-detected. A load is a sampled 0->1 transition at a rising sclk; a held level loads once. The previous-sample register resets to 0.
- States: SLEEP, ARM, RUN, EXIT. All outputs are registered.
- SLEEP: fetch_en=0, pc held. On load edge with wake=1: pc<=pc_in, runtime<=runtime_sel, run_cycles<=0, go to ARM. A load edge with wake=0 is ignored.
- ARM: exactly one cycle, fetch_en=0 (pipeline flush slot), then go to RUN. Load-to-first-fetch latency is 2 cycles.
- RUN: fetch_en=1, run_cycles increments each cycle and saturates at all-ones. Per-cycle priority, highest first:
  (1) wake=0 -> SLEEP (forced kill, no cpu_exit);
  (2) load edge -> reload pc/runtime, clear run_cycles, go to ARM;
  (3) exit_req -> go to EXIT, cpu_exit=1 for this transition cycle only;
  (4) stall=1 -> pc held, counter still increments;
  (5) branch_taken -> pc<=branch_target;
  (6) otherwise pc<=pc+PC_STEP, modulo 2^PC_W (wraps silently).
- EXIT: fetch_en=0, pc held. The timeout counter increments. wake=0 -> SLEEP and counter clears. If the counter reaches EXIT_TIMEOUT -> exit_err<=1, stay in EXIT. A load edge in EXIT is ignored.
- Simultaneous exit_req and branch_taken: exit wins, pc not updated.
- wake dropping in ARM -> SLEEP. The loaded pc is retained.

Optional Feature:
CPU1_PC_ALIGN_CHECK_EN.
- Defined: if pc_in or branch_target has nonzero bits [1:0] when used, align_err<=1 (sticky until reset) and the loaded value has bits [1:0] forced to 0.
- Undefined: values pass through unchanged and align_err is tied to 0.

Decomposition:
- Shared package holds: the state encoding typedef (SLEEP=2'b00, ARM=2'b01, RUN=2'b10, EXIT=2'b11), PC_STEP, and the RESET_PC constant shared with the dispatch unit.
- One sub-module, cpu1_exit_timer: the EXIT timeout counter and the sticky exit_err flag.

Test Plan:
- Reset mid-RUN (pc=0x40): reset=0 -> pc=0, fetch_en=0, state SLEEP at once, without waiting for sclk.
- wake=1, load edge with pc_in=0x100 -> ARM next cycle; fetch_en=1 with pc=0x100 two cycles after the edge; then 0x104, 0x108 on successive cycles.
- In RUN at pc=0x108: stall=1 for 3 cycles -> pc stays 0x108 while run_cycles advances 3. branch_taken with target 0x200 -> pc=0x200 next cycle.
- exit_req and branch_taken in the same cycle -> cpu_exit high exactly 1 cycle, pc unchanged, fetch_en=0. Drop wake 2 cycles later -> SLEEP, exit_err=0.
- Enter EXIT and keep wake=1 for 16 cycles -> exit_err=1 and stays set after wake drops.
- With CPU1_PC_ALIGN_CHECK_EN defined, pc_in=0x103 -> pc=0x100 and align_err=1. With the macro undefined -> pc=0x103 and align_err=0.

Source files
------------

// File: rtl/cpu1_pc_sequencer_pkg.sv
// Shared definitions for the CPU1 program-counter sequencer and the dispatch unit.
package cpu1_pc_sequencer_pkg;

  typedef enum logic [1:0] {
    SLEEP = 2'b00,
    ARM   = 2'b01,
    RUN   = 2'b10,
    EXIT  = 2'b11
  } cpu1_state_e;

  localparam int          CPU1_PC_STEP  = 4;
  localparam logic [31:0] CPU1_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/cpu1_exit_timer.sv
// Counts cycles spent in EXIT with wake still high and raises a sticky exit_err
// once EXIT_TIMEOUT cycles have elapsed.
module cpu1_exit_timer #(
  parameter int EXIT_TIMEOUT = 16
) (
  input  logic sclk,
  input  logic reset,
  input  logic i_active,
  input  logic i_wake,
  output logic o_exit_err
);

  localparam int CW = $clog2(EXIT_TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_exit_err;

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_exit_err <= 1'b0;
    end else if (i_active && i_wake) begin
      // Counter saturates at the timeout; the flag fires on the cycle it gets there.
      if (r_cnt != CW'(EXIT_TIMEOUT)) r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(EXIT_TIMEOUT - 1)) r_exit_err <= 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_exit_err = r_exit_err;

endmodule

// File: rtl/cpu1_pc_sequencer.sv
// CPU1 program counter owner: sleep/arm/run/exit sequencing, PC stepping and branching.
// Optional build macro CPU1_PC_ALIGN_CHECK_EN enables alignment checking of loaded PCs.
module cpu1_pc_sequencer
  import cpu1_pc_sequencer_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter int              PC_STEP      = CPU1_PC_STEP,
  parameter logic [PC_W-1:0] RESET_PC     = PC_W'(CPU1_RESET_PC),
  parameter int              EXIT_TIMEOUT = 16,
  parameter int              CNT_W        = 16
) (
  input  logic             sclk,
  input  logic             reset,
  input  logic             wake,
  input  logic             runtime_sel,
  input  logic             load_pc,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             exit_req,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_en,
  output logic             runtime,
  output logic             cpu_exit,
  output logic [CNT_W-1:0] run_cycles,
  output logic             exit_err,
  output logic             align_err
);

  cpu1_state_e      r_state, w_state_nxt;
  logic             r_load_prev;
  logic             w_load_edge;
  logic [PC_W-1:0]  r_pc;
  logic             r_fetch_en, r_runtime, r_cpu_exit, r_align_err;
  logic [CNT_W-1:0] r_run_cycles;
  logic [PC_W-1:0]  w_pc_in_fix, w_bt_fix;
  logic             w_pc_in_mis, w_bt_mis;

  assign w_load_edge = load_pc & ~r_load_prev;

`ifdef CPU1_PC_ALIGN_CHECK_EN
  assign w_pc_in_mis = |pc_in[1:0];
  assign w_bt_mis    = |branch_target[1:0];
  assign w_pc_in_fix = {pc_in[PC_W-1:2], 2'b00};
  assign w_bt_fix    = {branch_target[PC_W-1:2], 2'b00};
`else
  assign w_pc_in_mis = 1'b0;
  assign w_bt_mis    = 1'b0;
  assign w_pc_in_fix = pc_in;
  assign w_bt_fix    = branch_target;
`endif

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) r_state <= SLEEP;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLEEP: if (w_load_edge && wake) w_state_nxt = ARM;
      ARM:   w_state_nxt = wake ? RUN : SLEEP;
      RUN: begin
        if (!wake)            w_state_nxt = SLEEP;
        else if (w_load_edge) w_state_nxt = ARM;
        else if (exit_req)    w_state_nxt = EXIT;
      end
      EXIT:  if (!wake) w_state_nxt = SLEEP;
      default: w_state_nxt = SLEEP;
    endcase
  end

  // Registered outputs; fetch_en tracks the state being entered so it lines up with pc.
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      r_load_prev  <= 1'b0;
      r_pc         <= RESET_PC;
      r_fetch_en   <= 1'b0;
      r_runtime    <= 1'b0;
      r_cpu_exit   <= 1'b0;
      r_run_cycles <= '0;
      r_align_err  <= 1'b0;
    end else begin
      r_load_prev <= load_pc;
      r_fetch_en  <= (w_state_nxt == RUN);
      r_cpu_exit  <= (r_state == RUN) && wake && !w_load_edge && exit_req;
      case (r_state)
        SLEEP: begin
          if (w_load_edge && wake) begin
            r_pc         <= w_pc_in_fix;
            r_runtime    <= runtime_sel;
            r_run_cycles <= '0;
            if (w_pc_in_mis) r_align_err <= 1'b1;
          end
        end
        RUN: begin
          if (wake && w_load_edge) begin
            r_pc         <= w_pc_in_fix;
            r_runtime    <= runtime_sel;
            r_run_cycles <= '0;
            if (w_pc_in_mis) r_align_err <= 1'b1;
          end else begin
            if (r_run_cycles != {CNT_W{1'b1}}) r_run_cycles <= r_run_cycles + 1'b1;
            if (wake && !exit_req && !stall) begin
              if (branch_taken) begin
                r_pc <= w_bt_fix;
                if (w_bt_mis) r_align_err <= 1'b1;
              end else begin
                r_pc <= r_pc + PC_W'(PC_STEP);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  cpu1_exit_timer #(.EXIT_TIMEOUT(EXIT_TIMEOUT)) u_exit_timer (
    .sclk       (sclk),
    .reset      (reset),
    .i_active   (r_state == EXIT),
    .i_wake     (wake),
    .o_exit_err (exit_err)
  );

  assign pc         = r_pc;
  assign fetch_en   = r_fetch_en;
  assign runtime    = r_runtime;
  assign cpu_exit   = r_cpu_exit;
  assign run_cycles = r_run_cycles;
  assign align_err  = r_align_err;

endmodule

// File: tb/tb_cpu1_pc_sequencer.sv
// Directed bench for cpu1_pc_sequencer with hand-computed expectations.
module tb_cpu1_pc_sequencer;

  logic        sclk = 1'b0;
  logic        reset;
  logic        wake, runtime_sel, load_pc, stall, branch_taken, exit_req;
  logic [31:0] pc_in, branch_target;
  logic [31:0] pc;
  logic        fetch_en, runtime, cpu_exit, exit_err, align_err;
  logic [15:0] run_cycles;

  int n_chk = 0;
  int n_fail = 0;

  always #5 sclk = ~sclk;

  cpu1_pc_sequencer dut (
    .sclk          (sclk),
    .reset         (reset),
    .wake          (wake),
    .runtime_sel   (runtime_sel),
    .load_pc       (load_pc),
    .pc_in         (pc_in),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .exit_req      (exit_req),
    .pc            (pc),
    .fetch_en      (fetch_en),
    .runtime       (runtime),
    .cpu_exit      (cpu_exit),
    .run_cycles    (run_cycles),
    .exit_err      (exit_err),
    .align_err     (align_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  // Load edge then step into RUN: leaves the DUT in RUN with pc == a.
  task automatic load_and_run(input logic [31:0] a);
    wake = 1'b1; pc_in = a; load_pc = 1'b1;
    tick();
    load_pc = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0; wake = 1'b0; runtime_sel = 1'b0; load_pc = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; exit_req = 1'b0; pc_in = '0; branch_target = '0;
    #3;
    chk("rst_pc", pc, 32'h0);
    chk("rst_fetch_en", {31'd0, fetch_en}, 32'd0);
    chk("rst_runtime", {31'd0, runtime}, 32'd0);
    chk("rst_cpu_exit", {31'd0, cpu_exit}, 32'd0);
    chk("rst_run_cycles", {16'd0, run_cycles}, 32'd0);
    chk("rst_exit_err", {31'd0, exit_err}, 32'd0);
    chk("rst_align_err", {31'd0, align_err}, 32'd0);
    tick();
    reset = 1'b1;

    // Load with a held level: one load, 2-cycle latency to first fetch.
    wake = 1'b1; runtime_sel = 1'b1; pc_in = 32'h100; load_pc = 1'b1;
    tick();
    chk("arm_fetch_en", {31'd0, fetch_en}, 32'd0);
    chk("arm_pc", pc, 32'h100);
    pc_in = 32'h500;
    tick();
    chk("run_fetch_en", {31'd0, fetch_en}, 32'd1);
    chk("run_pc0", pc, 32'h100);
    chk("run_runtime", {31'd0, runtime}, 32'd1);
    tick();
    chk("run_pc1", pc, 32'h104);
    tick();
    chk("run_pc2", pc, 32'h108);
    chk("run_cyc2", {16'd0, run_cycles}, 32'd2);
    load_pc = 1'b0;

    stall = 1'b1;
    tick(3);
    chk("stall_pc", pc, 32'h108);
    chk("stall_cyc", {16'd0, run_cycles}, 32'd5);
    stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    chk("branch_pc", pc, 32'h200);
    branch_taken = 1'b0;
    tick();
    chk("step_pc", pc, 32'h204);

    // Exit and branch together: exit wins.
    exit_req = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
    tick();
    chk("exit_pulse", {31'd0, cpu_exit}, 32'd1);
    chk("exit_pc", pc, 32'h204);
    chk("exit_fetch_en", {31'd0, fetch_en}, 32'd0);
    exit_req = 1'b0; branch_taken = 1'b0;
    tick();
    chk("exit_pulse_end", {31'd0, cpu_exit}, 32'd0);
    tick();
    wake = 1'b0;
    tick();
    chk("exit_sleep_err", {31'd0, exit_err}, 32'd0);
    chk("exit_sleep_fetch", {31'd0, fetch_en}, 32'd0);
    load_pc = 1'b1; pc_in = 32'h500;
    tick(2);
    chk("sleep_nowake_load", pc, 32'h204);
    load_pc = 1'b0;
    tick();

    // Asynchronous reset in the middle of RUN.
    load_and_run(32'h40);
    chk("mid_run_pc", pc, 32'h40);
    chk("mid_run_fetch", {31'd0, fetch_en}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_fetch", {31'd0, fetch_en}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("async_rst_held_sleep", {31'd0, fetch_en}, 32'd0);

    // EXIT timeout: 16 cycles with wake high sets a sticky error.
    load_and_run(32'h80);
    chk("reload_cyc_zero", {16'd0, run_cycles}, 32'd0);
    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    tick(5);
    load_pc = 1'b1; pc_in = 32'h900;
    tick();
    load_pc = 1'b0;
    tick(9);
    chk("timeout_pre", {31'd0, exit_err}, 32'd0);
    chk("exit_load_ignored", pc, 32'h80);
    tick();
    chk("timeout_err", {31'd0, exit_err}, 32'd1);
    wake = 1'b0;
    tick(2);
    chk("timeout_sticky", {31'd0, exit_err}, 32'd1);
    chk("timeout_sleep_fetch", {31'd0, fetch_en}, 32'd0);

    // Alignment handling and wake dropping in ARM.
    do_reset();
    wake = 1'b1; pc_in = 32'h103; load_pc = 1'b1;
    tick();
    load_pc = 1'b0;
`ifdef CPU1_PC_ALIGN_CHECK_EN
    chk("align_pc", pc, 32'h100);
    chk("align_err", {31'd0, align_err}, 32'd1);
`else
    chk("align_pc", pc, 32'h103);
    chk("align_err", {31'd0, align_err}, 32'd0);
`endif
    wake = 1'b0;
    tick(2);
    chk("arm_kill_fetch", {31'd0, fetch_en}, 32'd0);
`ifdef CPU1_PC_ALIGN_CHECK_EN
    chk("arm_kill_pc", pc, 32'h100);
`else
    chk("arm_kill_pc", pc, 32'h103);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
